uart_tx_rx: RTL and testbench

UART_TX_RX -- requirements
Module: uart_tx_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_rx_if.sv | 44 ++++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/uart_tx_rx.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_rx.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver slice.
//   uart_state_e : state encoding used by both the TX and the RX FSM
//   DATA_BITS    : payload bits per frame (8N1 framing)
//   START_LEVEL  : line level of the start bit
//   STOP_LEVEL   : line level of the stop bit (also the idle level)
//   CNT_W        : width of the bit-cycle counter (covers 4..65535 cycles per bit)
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam int   CNT_W       = 16;

endpackage

// File: rtl/uart_tx_rx_if.sv
// Bundle of the UART user-side and line-side signals.
//   tx_data_valid   : transmit request (level)
//   tx_data_in      : byte to transmit
//   serial_data_out : TX line, idles high
//   tx_active       : high while a frame is on the line
//   tx_done         : one-cycle pulse on the last cycle of the stop bit
//   serial_in       : RX line, asynchronous to the clock
//   rx_data_out     : last correctly received byte
//   rx_data_valid   : one-cycle pulse when rx_data_out is updated
//   tx_state/rx_state : FSM state, for observation only
//
// Handshake: there is no ready signal. A request (tx_data_valid=1) is accepted
// on any rising edge where TX is idle (tx_active=0) or finishing a frame
// (tx_done=1); tx_data_in is captured on that same edge. Holding tx_data_valid
// high streams frames with no idle time between them. rx_data_valid is a
// single-cycle strobe with no back-pressure; rx_data_out holds until the next
// good byte.
interface uart_tx_rx_if;
    import uart_pkg::*;

    logic        tx_data_valid;
    logic [7:0]  tx_data_in;
    logic        serial_data_out;
    logic        tx_active;
    logic        tx_done;
    logic        serial_in;
    logic [7:0]  rx_data_out;
    logic        rx_data_valid;
    uart_state_e tx_state;
    uart_state_e rx_state;

    modport master (
        output tx_data_valid, tx_data_in, serial_in,
        input  serial_data_out, tx_active, tx_done, rx_data_out, rx_data_valid,
        input  tx_state, rx_state
    );

    modport slave (
        input  tx_data_valid, tx_data_in, serial_in,
        output serial_data_out, tx_active, tx_done, rx_data_out, rx_data_valid,
        output tx_state, rx_state
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period cycle counter shared by the TX and RX paths.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   clear        : hold the count at 0 (restart the period)
//   half         : count == (clk_per_bit-1)/2, the mid-bit point
//   full         : count == clk_per_bit-1, the last cycle of a bit; the
//                  counter wraps to 0 on the following edge
// clk_per_bit is expected in 4..65535.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int clk_per_bit = 104
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    output logic half,
    output logic full
);

    localparam logic [CNT_W-1:0] HALF_VAL = CNT_W'((clk_per_bit - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_VAL = CNT_W'(clk_per_bit - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
        end else if (clear || full) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign half = (count == HALF_VAL);
    assign full = (count == FULL_VAL);

endmodule

// File: rtl/uart_tx_rx.sv
// 8N1 UART transmitter and receiver running independently on one clock.
//   no_clk_per_bit : clock cycles per bit (4..65535)
//   i_clk          : sole clock, rising edge
//   i_rst          : asynchronous active-high reset; aborts any frame
//   bus            : uart_tx_rx_if.slave (request, line and status signals)
module uart_tx_rx
    import uart_pkg::*;
#(
    parameter int no_clk_per_bit = 104
) (
    input  logic         i_clk,
    input  logic         i_rst,
    uart_tx_rx_if.slave  bus
);

    // ------------------------------------------------------------ TX path
    uart_state_e tx_state, tx_next;
    logic [7:0]  tx_shreg;
    logic [2:0]  tx_idx;
    logic        tx_clear, tx_full, tx_half_unused;
    logic        tx_load;
    logic        tx_line, tx_act, tx_end;

    uart_bit_timer #(.clk_per_bit(no_clk_per_bit)) u_tx_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .clear (tx_clear),
        .half  (tx_half_unused),
        .full  (tx_full)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) tx_state <= ST_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            ST_IDLE:  if (bus.tx_data_valid) tx_next = ST_START;
            ST_START: if (tx_full) tx_next = ST_DATA;
            ST_DATA:  if (tx_full && tx_idx == 3'(DATA_BITS - 1)) tx_next = ST_STOP;
            // The last stop cycle doubles as the idle sampling point, so a
            // held request chains straight into the next start bit.
            ST_STOP:  if (tx_full) tx_next = bus.tx_data_valid ? ST_START : ST_IDLE;
            default:  tx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_clear = 1'b0;
        tx_load  = 1'b0;
        tx_line  = STOP_LEVEL;
        tx_act   = 1'b0;
        tx_end   = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                tx_clear = 1'b1;
                tx_load  = bus.tx_data_valid;
            end
            ST_START: begin
                tx_line = START_LEVEL;
                tx_act  = 1'b1;
            end
            ST_DATA: begin
                tx_line = tx_shreg[tx_idx];
                tx_act  = 1'b1;
            end
            ST_STOP: begin
                tx_line = STOP_LEVEL;
                tx_act  = 1'b1;
                tx_end  = tx_full;
                tx_load = tx_full && bus.tx_data_valid;
            end
            default: tx_clear = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_shreg <= '0;
            tx_idx   <= '0;
        end else if (tx_load) begin
            tx_shreg <= bus.tx_data_in;
            tx_idx   <= '0;
        end else if (tx_state == ST_DATA && tx_full) begin
            tx_idx <= tx_idx + 3'd1;
        end
    end

    // Line and status come straight from the state, so reset forces the
    // line high and tx_active low without waiting for a clock edge.
    assign bus.serial_data_out = tx_line;
    assign bus.tx_active       = tx_act;
    assign bus.tx_done         = tx_end;
    assign bus.tx_state        = tx_state;

    // ------------------------------------------------------------ RX path
    logic        rx_meta, rx_sync;
    uart_state_e rx_state, rx_next;
    logic [7:0]  rx_shreg;
    logic [2:0]  rx_idx;
    logic        rx_err;
    logic        rx_clear, rx_half, rx_full;
    logic        rx_shift, rx_commit, rx_flag_err;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;

    // Two-flop synchronizer; resets to the idle (stop) level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= STOP_LEVEL;
            rx_sync <= STOP_LEVEL;
        end else begin
            rx_meta <= bus.serial_in;
            rx_sync <= rx_meta;
        end
    end

    uart_bit_timer #(.clk_per_bit(no_clk_per_bit)) u_rx_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .clear (rx_clear),
        .half  (rx_half),
        .full  (rx_full)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) rx_state <= ST_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            ST_IDLE:  if (rx_sync == START_LEVEL) rx_next = ST_START;
            // Re-check the start bit at its middle; a high line was a glitch.
            ST_START: if (rx_half) rx_next = (rx_sync == START_LEVEL) ? ST_DATA : ST_IDLE;
            ST_DATA:  if (rx_full && rx_idx == 3'(DATA_BITS - 1)) rx_next = ST_STOP;
            ST_STOP: begin
                if (rx_err) begin
                    // Framing error: wait for the line to go back to idle.
                    if (rx_sync == STOP_LEVEL) rx_next = ST_IDLE;
                end else if (rx_full && rx_sync == STOP_LEVEL) begin
                    rx_next = ST_IDLE;
                end
            end
            default:  rx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_clear    = 1'b0;
        rx_shift    = 1'b0;
        rx_commit   = 1'b0;
        rx_flag_err = 1'b0;
        case (rx_state)
            ST_IDLE:  rx_clear = 1'b1;
            // Restart the period at mid-start so every later full flag
            // lands in the middle of a bit.
            ST_START: rx_clear = rx_half;
            ST_DATA:  rx_shift = rx_full;
            ST_STOP: begin
                if (rx_err) begin
                    rx_clear = 1'b1;
                end else if (rx_full) begin
                    rx_commit   = (rx_sync == STOP_LEVEL);
                    rx_flag_err = (rx_sync != STOP_LEVEL);
                end
            end
            default:  rx_clear = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_shreg   <= '0;
            rx_idx     <= '0;
            rx_err     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= rx_commit;
            if (rx_commit) begin
                rx_data_q <= rx_shreg;
            end
            if (rx_shift) begin
                rx_shreg <= {rx_sync, rx_shreg[7:1]};
                rx_idx   <= rx_idx + 3'd1;
            end
            if (rx_flag_err) begin
                rx_err <= 1'b1;
            end else if (rx_state == ST_STOP && rx_err && rx_sync == STOP_LEVEL) begin
                rx_err <= 1'b0;
            end
        end
    end

    assign bus.rx_data_out   = rx_data_q;
    assign bus.rx_data_valid = rx_valid_q;
    assign bus.rx_state      = rx_state;

endmodule

// File: tb/tb_uart_tx_rx.sv
// Bench for uart_tx_rx: three instances (104, 4 and 87 cycles per bit), the
// 104 one switchable between loopback and a bench-driven line.
`timescale 1ns/1ps
module tb_uart_tx_rx;
    import uart_pkg::*;

    // ------------------------------------------------ clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------ DUTs
    uart_tx_rx_if bus104();
    uart_tx_rx_if bus4();
    uart_tx_rx_if bus87();

    logic       lb104;
    logic       drv_line;
    logic       tx_valid [3];
    logic [7:0] tx_data  [3];

    assign bus104.tx_data_valid = tx_valid[0];
    assign bus4.tx_data_valid   = tx_valid[1];
    assign bus87.tx_data_valid  = tx_valid[2];
    assign bus104.tx_data_in    = tx_data[0];
    assign bus4.tx_data_in      = tx_data[1];
    assign bus87.tx_data_in     = tx_data[2];
    assign bus104.serial_in     = lb104 ? bus104.serial_data_out : drv_line;
    assign bus4.serial_in       = bus4.serial_data_out;
    assign bus87.serial_in      = bus87.serial_data_out;

    uart_tx_rx #(.no_clk_per_bit(104)) dut104 (.i_clk(clk), .i_rst(rst), .bus(bus104));
    uart_tx_rx #(.no_clk_per_bit(4))   dut4   (.i_clk(clk), .i_rst(rst), .bus(bus4));
    uart_tx_rx #(.no_clk_per_bit(87))  dut87  (.i_clk(clk), .i_rst(rst), .bus(bus87));

    logic       line_o [3];
    logic       act_o  [3];
    logic       done_o [3];
    logic       rv_o   [3];
    logic [7:0] rd_o   [3];
    assign line_o[0] = bus104.serial_data_out;
    assign line_o[1] = bus4.serial_data_out;
    assign line_o[2] = bus87.serial_data_out;
    assign act_o[0]  = bus104.tx_active;
    assign act_o[1]  = bus4.tx_active;
    assign act_o[2]  = bus87.tx_active;
    assign done_o[0] = bus104.tx_done;
    assign done_o[1] = bus4.tx_done;
    assign done_o[2] = bus87.tx_done;
    assign rv_o[0]   = bus104.rx_data_valid;
    assign rv_o[1]   = bus4.rx_data_valid;
    assign rv_o[2]   = bus87.rx_data_valid;
    assign rd_o[0]   = bus104.rx_data_out;
    assign rd_o[1]   = bus4.rx_data_out;
    assign rd_o[2]   = bus87.rx_data_out;

    int nbit [3] = '{104, 4, 87};

    // ------------------------------------------------ scoreboard state
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    logic [7:0] last_rx104;

    int         bit_err [20];
    int         done_at [$];
    logic [7:0] rx_got  [$];
    int         act_err;
    int         idle_err;

    // ------------------------------------------------ drivers
    // Requests nb frames (b0, then b1 if nb==2) on DUT d and records, cycle by
    // cycle, how the line differs from the ideal 8N1 waveform, plus every
    // tx_done and rx_data_valid seen. For nb==1, b1 is presented mid-frame
    // and must be ignored.
    task automatic drive_frames(input int d, input int nb, input logic [7:0] b0,
                                input logic [7:0] b1);
        int n = nbit[d];
        int flen = 10 * n;
        int total = nb * flen + n + 20;
        logic [9:0] fb;
        for (int i = 0; i < 20; i++) bit_err[i] = 0;
        done_at.delete();
        rx_got.delete();
        act_err = 0;
        idle_err = 0;
        @(negedge clk);
        tx_valid[d] = 1'b1;
        tx_data[d]  = b0;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c == 0) tx_data[d] = b1;
            if (c == (nb - 1) * flen) tx_valid[d] = 1'b0;
            if (c < nb * flen) begin
                fb = {STOP_LEVEL, ((c / flen) == 0) ? b0 : b1, START_LEVEL};
                if (line_o[d] !== fb[(c % flen) / n]) bit_err[(c / flen) * 10 + (c % flen) / n]++;
                if (act_o[d] !== 1'b1) act_err++;
            end else if (line_o[d] !== 1'b1 || act_o[d] !== 1'b0) begin
                idle_err++;
            end
            if (done_o[d] === 1'b1) done_at.push_back(c);
            if (rv_o[d] === 1'b1) rx_got.push_back(rd_o[d]);
        end
    endtask

    // Drives a 10-bit frame (LSB first) onto the 104 DUT's RX line, then
    // tail_low extra low bit times, then two idle bit times.
    task automatic drive_line(input logic [9:0] fb, input int tail_low,
                              output int pulses, output logic [7:0] last);
        pulses = 0;
        last = 8'h00;
        for (int b = 0; b < 12 + tail_low; b++) begin
            for (int k = 0; k < 104; k++) begin
                @(negedge clk);
                drv_line = (b < 10) ? fb[b] : ((b < 10 + tail_low) ? 1'b0 : 1'b1);
                if (rv_o[0] === 1'b1) begin
                    pulses++;
                    last = rd_o[0];
                end
            end
        end
    endtask

    // ------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (line_o[d] !== 1'b1) begin
                n_err++;
                $display("FAIL reset_line[%0d]: got %b want 1", d, line_o[d]);
            end
            n_cmp++;
            if (act_o[d] !== 1'b0 || done_o[d] !== 1'b0 || rv_o[d] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_flags[%0d]: active=%b done=%b rx_valid=%b want 0 0 0",
                         d, act_o[d], done_o[d], rv_o[d]);
            end
            n_cmp++;
            if (rd_o[d] !== 8'h00) begin
                n_err++;
                $display("FAIL reset_rx_data[%0d]: got %h want 00", d, rd_o[d]);
            end
        end
        n_cmp++;
        if (bus104.tx_state !== ST_IDLE || bus104.rx_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_states: tx=%0d rx=%0d want 0 0", bus104.tx_state, bus104.rx_state);
        end
        last_rx104 = 8'h00;
    endtask

    task automatic test_loopback(input string name, input int d, input logic [7:0] b0,
                                 input logic [7:0] b1);
        int flen = 10 * nbit[d];
        logic [7:0] want;
        exp_q.push_back(b0);
        drive_frames(d, 1, b0, b1);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (bit_err[i] != 0) begin
                n_err++;
                $display("FAIL %s line_bit%0d: got %0d wrong cycles want 0", name, i, bit_err[i]);
            end
        end
        n_cmp++;
        if (act_err != 0 || idle_err != 0) begin
            n_err++;
            $display("FAIL %s tx_active: got %0d/%0d bad cycles want 0/0", name, act_err, idle_err);
        end
        n_cmp++;
        if (done_at.size() != 1 || done_at[0] != flen - 1) begin
            n_err++;
            $display("FAIL %s tx_done: got %0d pulses first at %0d want 1 at %0d", name,
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1, flen - 1);
        end
        want = exp_q.pop_front();
        n_cmp++;
        if (rx_got.size() != 1 || rx_got[0] !== want) begin
            n_err++;
            $display("FAIL %s rx_byte: got %0d pulses first %h want 1 of %h", name,
                     rx_got.size(), (rx_got.size() > 0) ? rx_got[0] : 8'hxx, want);
        end
        if (d == 0) last_rx104 = want;
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        drive_frames(0, 2, 8'h00, 8'hFF);
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (bit_err[i] != 0) begin
                n_err++;
                $display("FAIL b2b line_bit%0d: got %0d wrong cycles want 0", i, bit_err[i]);
            end
        end
        n_cmp++;
        if (act_err != 0 || idle_err != 0) begin
            n_err++;
            $display("FAIL b2b tx_active: got %0d/%0d bad cycles want 0/0", act_err, idle_err);
        end
        n_cmp++;
        if (done_at.size() != 2 || done_at[0] != 1039 || done_at[1] != 2079) begin
            n_err++;
            $display("FAIL b2b tx_done: got %0d pulses at %0d,%0d want 2 at 1039,2079",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1,
                     (done_at.size() > 1) ? done_at[1] : -1);
        end
        n_cmp++;
        if (rx_got.size() != 2) begin
            n_err++;
            $display("FAIL b2b rx_count: got %0d want 2", rx_got.size());
        end
        for (int i = 0; i < 2; i++) begin
            want = exp_q.pop_front();
            n_cmp++;
            if (rx_got.size() <= i || rx_got[i] !== want) begin
                n_err++;
                $display("FAIL b2b rx_byte%0d: got %h want %h", i,
                         (rx_got.size() > i) ? rx_got[i] : 8'hxx, want);
            end
        end
        last_rx104 = 8'hFF;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            test_loopback("random104", 0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        test_loopback("random87", 2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    task automatic test_glitch();
        int pulses = 0;
        lb104 = 1'b0;
        drv_line = 1'b1;
        repeat (10) @(negedge clk);
        for (int c = 0; c < 30 + 3 * 104; c++) begin
            drv_line = (c < 30) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (rv_o[0] === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL glitch_pulse: got %0d rx_data_valid pulses want 0", pulses);
        end
        n_cmp++;
        if (bus104.rx_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL glitch_state: got %0d want %0d", bus104.rx_state, ST_IDLE);
        end
        n_cmp++;
        if (rd_o[0] !== last_rx104) begin
            n_err++;
            $display("FAIL glitch_rx_data: got %h want %h", rd_o[0], last_rx104);
        end
    endtask

    task automatic test_framing_error();
        int pulses;
        logic [7:0] last;
        lb104 = 1'b0;
        drive_line({1'b0, 8'h55, START_LEVEL}, 1, pulses, last);
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL frame_err_pulse: got %0d pulses want 0", pulses);
        end
        n_cmp++;
        if (rd_o[0] !== last_rx104) begin
            n_err++;
            $display("FAIL frame_err_rx_data: got %h want %h", rd_o[0], last_rx104);
        end
        n_cmp++;
        if (bus104.rx_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL frame_err_state: got %0d want %0d", bus104.rx_state, ST_IDLE);
        end
        // A clean frame afterwards must be received normally.
        drive_line({STOP_LEVEL, 8'h3C, START_LEVEL}, 0, pulses, last);
        n_cmp++;
        if (pulses != 1 || last !== 8'h3C) begin
            n_err++;
            $display("FAIL frame_recover: got %0d pulses byte %h want 1 of 3c", pulses, last);
        end
        last_rx104 = 8'h3C;
        lb104 = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int n_done = 0;
        int n_rv = 0;
        int n_line = 0;
        lb104 = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hF0;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        // Start bit is cycle 0 here; frame bit 4 is data bit 3 (a 0 for F0).
        repeat (4 * 104 + 52) @(negedge clk);
        n_cmp++;
        if (line_o[0] !== 1'b0 || act_o[0] !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_bit3: line=%b active=%b want 0 1", line_o[0], act_o[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (line_o[0] !== 1'b1 || act_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort: line=%b active=%b done=%b want 1 0 0",
                     line_o[0], act_o[0], done_o[0]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12 * 104; c++) begin
            @(negedge clk);
            if (done_o[0] === 1'b1) n_done++;
            if (rv_o[0] === 1'b1) n_rv++;
            if (line_o[0] !== 1'b1) n_line++;
        end
        n_cmp++;
        if (n_done != 0 || n_rv != 0) begin
            n_err++;
            $display("FAIL reset_no_pulse: got tx_done=%0d rx_valid=%0d want 0 0", n_done, n_rv);
        end
        n_cmp++;
        if (n_line != 0) begin
            n_err++;
            $display("FAIL reset_line_idle: got %0d low cycles want 0", n_line);
        end
        n_cmp++;
        if (rd_o[0] !== 8'h00) begin
            n_err++;
            $display("FAIL reset_rx_cleared: got %h want 00", rd_o[0]);
        end
        last_rx104 = 8'h00;
    endtask

    task automatic test_param_sweep();
        test_loopback("sweep4", 1, 8'hA5, 8'h5A);
        test_loopback("sweep87", 2, 8'hA5, 8'h0F);
    endtask

    // ------------------------------------------------ sequence + report
    initial begin
        rst      = 1'b1;
        lb104    = 1'b1;
        drv_line = 1'b1;
        for (int d = 0; d < 3; d++) begin
            tx_valid[d] = 1'b0;
            tx_data[d]  = 8'h00;
        end
        test_reset();
        test_loopback("loop_ab", 0, 8'hAB, 8'h12);
        test_back_to_back();
        test_random();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
